// File: rtl/prior_pkg.sv
// Shared definitions for the registered priority arbiter/encoder.
// Provides the priority mode encoding and the round-robin pointer step.
package prior_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Pointer moves one below the last grant, wrapping 0 -> n-1.
    function automatic int unsigned next_ptr(input int unsigned sel, input int unsigned n);
        return (sel == 0) ? n - 1 : sel - 1;
    endfunction

endpackage

// File: rtl/prior_pick.sv
// Combinational picker: first set bit of eff scanning downward from start,
// wrapping from index 0 back to N_REQ-1.
module prior_pick #(
    parameter int unsigned  N_REQ = 8,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eff,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] sel,
    output logic             found
);

    logic [IDX_W:0] w_cand;

    // start + N_REQ - k, folded back into range, avoids a negative intermediate.
    always_comb begin
        sel    = '0;
        found  = 1'b0;
        w_cand = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, start} + (IDX_W+1)'(N_REQ - k);
            if (w_cand >= (IDX_W+1)'(N_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(N_REQ);
            end
            if (!found && eff[w_cand[IDX_W-1:0]]) begin
                sel   = w_cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prior_arb_enc.sv
// Registered priority encoder with request latching and a valid/ready output.
// Fixed (highest index wins) or round-robin selection over pending | req.
module prior_arb_enc
    import prior_pkg::*;
#(
    parameter int unsigned  N_REQ = 8,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] pending
);

    logic [N_REQ-1:0] r_pending;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;

    logic [N_REQ-1:0] w_eff;
    logic [N_REQ-1:0] w_onehot;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_sel;
    logic             w_found;
    logic             w_rr;
    logic             w_load;

    assign w_rr     = (mode_e'(mode) == MODE_RR);
    assign w_eff    = r_pending | req;
    assign w_start  = w_rr ? r_ptr : IDX_W'(N_REQ - 1);
    assign w_onehot = N_REQ'(1) << w_sel;
    assign w_load   = w_found && (!r_valid || out_ready);

    prior_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .eff   (w_eff),
        .start (w_start),
        .sel   (w_sel),
        .found (w_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_ptr     <= IDX_W'(N_REQ - 1);
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_idx     <= w_sel;
            r_pending <= w_eff & ~w_onehot;
            if (w_rr) begin
                r_ptr <= IDX_W'(next_ptr(32'(w_sel), N_REQ));
            end
        end else begin
            r_pending <= w_eff;
            if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign pending   = r_pending;

endmodule
